sig16b_to_double: RTL and testbench

- Converts a 16-bit sign-magnitude audio sample (bit 15 sign, bits 14:0 unsigned integer magnitude) into an IEEE-754 double.
- Return-direction partner of the double-to-16-bit converter. Feeds echo-canceller sample words into the double-precision filter datapath.
- Normalisation is iterative: one leading-zero shift per clock, so it uses one shifter and no priority encoder.
- Single-sample handshake: enable to accept a sample, busy while converting, a one-cycle valid pulse with the result.

---
 rtl/sig16b_to_double.sv | 106 ++++++++++
 tb/tb_sig16b_to_double.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sig16b_to_double.sv
// rtl/sig16b_to_double.sv - sign-magnitude 16-bit sample to IEEE-754 double converter
//
// Purpose:
//   Accepts one 16-bit sign-magnitude sample (bit 15 sign, bits 14:0 integer
//   magnitude) and produces the exactly equal IEEE-754 double. Normalisation
//   shifts the magnitude left by one bit per clock until bit 14 is set, so a
//   single shifter replaces a priority encoder.
//
// Ports:
//   clk_sampling  in   1   sample-domain clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   enable        in   1   sample strobe, accepted only while busy=0
//   sig16b        in  16   sign-magnitude sample, captured on the accepting edge
//   double        out 64   IEEE-754 result, held until the next result
//   valid         out  1   one-cycle pulse, double is new in this cycle
//   busy          out  1   high while a conversion is in progress

module sig16b_to_double #(
    parameter int MSB_EXP = 14
) (
    input  logic        clk_sampling,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sig16b,
    output logic [63:0] double,
    output logic        valid,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic        [14:0] mag_q, mag_d;
    logic               sign_q, sign_d;
    // Unbiased exponent of magnitude bit 14; 11 bits signed covers any
    // MSB_EXP whose field 1023+cnt still fits the 11-bit exponent.
    logic signed [10:0] cnt_q, cnt_d;
    logic        [63:0] double_q, double_d;
    logic               valid_q, valid_d;
    logic        [10:0] exp_field;

    assign exp_field = 11'd1023 + cnt_q;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        double_d = double_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    sign_d  = sig16b[15];
                    mag_d   = sig16b[14:0];
                    cnt_d   = 11'(MSB_EXP);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == 15'd0) begin
                    // Zero magnitude has no leading one: emit signed zero.
                    double_d = {sign_q, 63'd0};
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else if (mag_q[14]) begin
                    // Bit 14 is the hidden one; 14 bits below it are exact.
                    double_d = {sign_q, exp_field, mag_q[13:0], 38'd0};
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mag_d = {mag_q[13:0], 1'b0};
                    cnt_d = cnt_q - 11'sd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sampling or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            double_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            double_q <= double_d;
            valid_q  <= valid_d;
        end
    end

    assign double = double_q;
    assign valid  = valid_q;
    assign busy   = (state_q == NORM);

endmodule

// File: tb/tb_sig16b_to_double.sv
// tb/tb_sig16b_to_double.sv - directed vector bench for sig16b_to_double

module tb_sig16b_to_double;

    logic        clk_sampling;
    logic        rst;
    logic        enable;
    logic [15:0] sig16b;
    logic [63:0] double;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sig16b_to_double #(.MSB_EXP(14)) dut (
        .clk_sampling(clk_sampling),
        .rst         (rst),
        .enable      (enable),
        .sig16b      (sig16b),
        .double      (double),
        .valid       (valid),
        .busy        (busy)
    );

    initial clk_sampling = 1'b0;
    always #5 clk_sampling = ~clk_sampling;

    typedef struct {
        logic [15:0] sample;
        logic [63:0] exp_double;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Waits up to 40 edges for valid; returns the edge count after T0, or -1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_sampling);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    // Pulses enable for exactly one edge (T0) and checks busy just after it.
    task automatic start(input logic [15:0] s, input string name);
        @(negedge clk_sampling);
        enable = 1'b1;
        sig16b = s;
        @(posedge clk_sampling);
        #1;
        enable = 1'b0;
        sig16b = 16'h0;
        check64({name, "_busy_after_T0"}, 64'(busy), 64'd1);
    endtask

    task automatic count_valids(input int edges, output int cnt);
        cnt = 0;
        for (int n = 0; n < edges; n++) begin
            @(posedge clk_sampling);
            #1;
            if (valid) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0] = '{16'h4000, 64'h40D0_0000_0000_0000, 1};
        vecs[1] = '{16'h0001, 64'h3FF0_0000_0000_0000, 15};
        vecs[2] = '{16'h0003, 64'h4008_0000_0000_0000, 14};
        vecs[3] = '{16'hFFFF, 64'hC0DF_FFC0_0000_0000, 1};
        vecs[4] = '{16'h8000, 64'h8000_0000_0000_0000, 1};
        vecs[5] = '{16'h7FFF, 64'h40DF_FFC0_0000_0000, 1};
        vecs[6] = '{16'h0002, 64'h4000_0000_0000_0000, 14};
        vecs[7] = '{16'h8001, 64'hBFF0_0000_0000_0000, 15};
        vecs[8] = '{16'h0100, 64'h4070_0000_0000_0000, 7};
        vecs[9] = '{16'h0005, 64'h4014_0000_0000_0000, 13};

        rst    = 1'b1;
        enable = 1'b0;
        sig16b = 16'h0;
        #12;
        check64("reset_double", double, 64'h0);
        check64("reset_valid", 64'(valid), 64'd0);
        check64("reset_busy", 64'(busy), 64'd0);

        @(negedge clk_sampling);
        rst = 1'b0;
        count_valids(5, cnt);
        check_int("idle_no_valid", cnt, 0);

        foreach (vecs[i]) begin
            start(vecs[i].sample, $sformatf("vec%0d", i));
            wait_valid(lat);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check64($sformatf("vec%0d_double", i), double, vecs[i].exp_double);
            check64($sformatf("vec%0d_busy_at_valid", i), 64'(busy), 64'd0);
            @(posedge clk_sampling);
            #1;
            check64($sformatf("vec%0d_valid_one_cycle", i), 64'(valid), 64'd0);
            check64($sformatf("vec%0d_double_held", i), double, vecs[i].exp_double);
        end

        // enable while busy is dropped
        start(16'h0001, "busy_ign");
        repeat (4) @(posedge clk_sampling);
        @(negedge clk_sampling);
        enable = 1'b1;
        sig16b = 16'h4000;
        @(posedge clk_sampling);
        #1;
        enable = 1'b0;
        wait_valid(lat);
        check_int("busy_ign_latency", lat, 10);
        check64("busy_ign_double", double, 64'h3FF0_0000_0000_0000);
        count_valids(20, cnt);
        check_int("busy_ign_no_second", cnt, 0);

        // enable held through the valid cycle captures the next sample
        @(negedge clk_sampling);
        enable = 1'b1;
        sig16b = 16'h0003;
        @(posedge clk_sampling);
        #1;
        sig16b = 16'h4000;
        wait_valid(lat);
        check_int("b2b_first_latency", lat, 14);
        check64("b2b_first_double", double, 64'h4008_0000_0000_0000);
        @(posedge clk_sampling);
        #1;
        check64("b2b_capture_busy", 64'(busy), 64'd1);
        check64("b2b_gap_valid", 64'(valid), 64'd0);
        @(posedge clk_sampling);
        #1;
        enable = 1'b0;
        check64("b2b_second_valid", 64'(valid), 64'd1);
        check64("b2b_second_double", double, 64'h40D0_0000_0000_0000);
        count_valids(20, cnt);
        check_int("b2b_no_third", cnt, 0);

        // asynchronous reset mid-conversion
        start(16'h0001, "rst_mid");
        repeat (7) @(posedge clk_sampling);
        #2;
        rst = 1'b1;
        #1;
        check64("rst_mid_double", double, 64'h0);
        check64("rst_mid_valid", 64'(valid), 64'd0);
        check64("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk_sampling);
        rst = 1'b0;
        count_valids(20, cnt);
        check_int("rst_mid_no_valid", cnt, 0);
        check64("rst_mid_double_after", double, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
